// File: rtl/am_put_pkg.sv
// rtl/am_put_pkg.sv - shared state encoding and default parameters for the American-put sequencer
package am_put_pkg;

  localparam int NSTEP_W_DEF    = 13;
  localparam int FP_W_DEF       = 64;
  localparam int WDOG_LIMIT_DEF = 20000;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LAUNCH_VEX  = 3'd1,
    ST_WAIT_VEX    = 3'd2,
    ST_LAUNCH_STEP = 3'd3,
    ST_WAIT_STEP   = 3'd4,
    ST_FINISH      = 3'd5
  } seq_state_t;

endpackage

// File: rtl/am_put_seq_wdog.sv
// rtl/am_put_seq_wdog.sv - wait-state watchdog: cleared on launch, counts while enabled, flags the last allowed cycle
module am_put_seq_wdog
  import am_put_pkg::*;
#(
  parameter int LIMIT = WDOG_LIMIT_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Holds at LAST so the count can never wrap if the caller lingers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/am_put_sequencer.sv
// rtl/am_put_sequencer.sv - job-level controller for the American-put lattice engine; SEQ_PERF_CNT_EN adds a job latency counter
module am_put_sequencer
  import am_put_pkg::*;
#(
  parameter int NSTEP_W    = NSTEP_W_DEF,
  parameter int FP_W       = FP_W_DEF,
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NSTEP_W-1:0] job_nsteps,
  input  logic [FP_W-1:0]    job_log_lambda_up,
  input  logic [FP_W-1:0]    job_log_lambda_down,
  input  logic [FP_W-1:0]    job_k_over_s,
  output logic               vex_start,
  output logic [FP_W-1:0]    vex_log_lambda_up,
  output logic [FP_W-1:0]    vex_log_lambda_down,
  output logic [FP_W-1:0]    vex_k_over_s,
  input  logic               vex_done,
  output logic               step_start,
  output logic [NSTEP_W-1:0] step_index,
  input  logic               step_done,
  input  logic               abort,
  output logic               busy,
  output logic               job_done,
  output logic               job_err,
  output logic [31:0]        perf_cycles
);

  seq_state_t         state, state_nxt;
  logic [NSTEP_W-1:0] nsteps_q;
  logic               err_q;
  logic               accept, err_set, idx_load, idx_dec;
  logic               wdog_clr, wdog_en, wdog_expired;

  assign accept = job_valid && job_ready;

  am_put_seq_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Priority inside each wait state: abort, then the done pulse, then watchdog expiry.
  always_comb begin
    state_nxt  = state;
    err_set    = 1'b0;
    idx_load   = 1'b0;
    idx_dec    = 1'b0;
    job_ready  = 1'b0;
    vex_start  = 1'b0;
    step_start = 1'b0;
    job_done   = 1'b0;
    busy       = 1'b1;
    wdog_clr   = 1'b0;
    wdog_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (job_valid) state_nxt = ST_LAUNCH_VEX;
      end
      ST_LAUNCH_VEX: begin
        vex_start = 1'b1;
        wdog_clr  = 1'b1;
        err_set   = abort;
        state_nxt = abort ? ST_FINISH : ST_WAIT_VEX;
      end
      ST_WAIT_VEX: begin
        wdog_en = 1'b1;
        if (abort) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end else if (vex_done) begin
          idx_load  = (nsteps_q != '0);
          state_nxt = (nsteps_q == '0) ? ST_FINISH : ST_LAUNCH_STEP;
        end else if (wdog_expired) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_LAUNCH_STEP: begin
        step_start = 1'b1;
        wdog_clr   = 1'b1;
        err_set    = abort;
        state_nxt  = abort ? ST_FINISH : ST_WAIT_STEP;
      end
      ST_WAIT_STEP: begin
        wdog_en = 1'b1;
        if (abort) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end else if (step_done) begin
          idx_dec   = (step_index != '0);
          state_nxt = (step_index == '0) ? ST_FINISH : ST_LAUNCH_STEP;
        end else if (wdog_expired) begin
          err_set   = 1'b1;
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        job_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign job_err = job_done && err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nsteps_q            <= '0;
      vex_log_lambda_up   <= '0;
      vex_log_lambda_down <= '0;
      vex_k_over_s        <= '0;
      step_index          <= '0;
      err_q               <= 1'b0;
    end else begin
      if (accept) begin
        nsteps_q            <= job_nsteps;
        vex_log_lambda_up   <= job_log_lambda_up;
        vex_log_lambda_down <= job_log_lambda_down;
        vex_k_over_s        <= job_k_over_s;
        err_q               <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (idx_load) begin
        step_index <= nsteps_q - NSTEP_W'(1);
      end else if (idx_dec) begin
        step_index <= step_index - NSTEP_W'(1);
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // The reported figure counts every busy cycle of the job, FINISH included.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (accept) begin
        perf_cnt <= '0;
      end else if (busy && perf_cnt != 32'hFFFF_FFFF) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
      if (job_done) begin
        perf_cycles <= (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_cycles = 32'd0;
`endif

endmodule
